mem_stage: RTL and testbench
============================

# mem_stage

Memory stage of the core_lapido pipeline. Combines a branch resolution unit, which decides from the EX/MEM control bits and the ALU flags whether a jump or branch is taken, with a word-addressed synchronous-write data memory. All other EX/MEM fields pass through to the MEM/WB register.

## Interface
Parameters:
- PC_WIDTH, 32, width of PC values.
- MEM_AW, 10, log2 of data memory depth in 32-bit words (1024 words).

Ports:
- clk  in  1  clock; memory writes occur on the rising edge.
- rst  in  1  reset, asynchronous, active-low; clears every memory word to 0.
- is_branch  in  1  instruction is a jump/branch.
- sel_jflag_branch  in  1  0 = flag jump (jt/jf), 1 = branch (beq/bne).
- sel_jt_jf  in  1  0 = jt, 1 = jf.
- sel_beq_bne  in  1  0 = beq, 1 = bne.
- flag_code  in  5  index of the flag tested by jt/jf.
- flags  in  6  ALU flags: [0] TRUE, [1] NEG, [2] ZERO, [3] CARRY, [4] NEGZERO, [5] OVERFLOW.
- mem_write  in  1  write enable.
- mem_addr  in  32  data address (rs data).
- mem_data  in  32  store data (rt data).
- next_pc  in  PC_WIDTH  sequential PC.
- branch_addr  in  PC_WIDTH  branch/jump target.
- wb_res_mux  in  2  write-back select, passed through.
- alu_res  in  32  ALU result, passed through.
- reg_dst  in  5  destination register, passed through.
- immediate  in  32  immediate, passed through.
- branch_taken  out  1  resolved branch decision.
- out_target  out  PC_WIDTH  branch_taken ? branch_addr : next_pc.
- out_next_pc  out  PC_WIDTH  = next_pc.
- out_mem_data  out  32  memory read data.
- out_wb_res_mux, out_alu_res, out_reg_dst, out_im  out  2/32/5/32  pass-throughs.

## Operation
Flag codes (FL_*):
- TRUE = 0, NEG = 1, ZERO = 2, CARRY = 3, NEGZERO = 4, OVERFLOW = 5.
- sel_flag = flags[flag_code] for codes 0–5; any code of 6 or above gives sel_flag = 0.

Branch decision:
- is_branch = 0: branch_taken = 0, regardless of all other inputs.
- is_branch = 1, sel_jflag_branch = 0: jt takes when sel_flag = 1; jf takes when sel_flag = 0.
- is_branch = 1, sel_jflag_branch = 1: beq takes when flags[2] (ZERO) = 1; bne takes when flags[2] = 0. flag_code is ignored in this mode.
- sel_beq_bne is don't-care in jump mode; sel_jt_jf is don't-care in branch mode.

Data memory:
- 2^MEM_AW words of 32 bits, word index = mem_addr[MEM_AW-1:0]; upper address bits are ignored, so addresses wrap.
- Read is combinational: out_mem_data = mem[index], whether or not mem_write is asserted.
- Write: when mem_write = 1 and rst = 1, mem[index] <= mem_data on the rising edge of clk.

Pass-throughs are purely combinational, with no state.

## Timing
- branch_taken, out_target, pass-throughs and out_mem_data are combinational and settle within the same cycle.
- Store latency is 1 edge. A read of the same address in the same cycle returns the old data before the edge and the new data after it.
- Reset:
  - rst low clears all words immediately, asynchronously, so out_mem_data = 0; writes are blocked while rst is low.
  - Combinational outputs are unaffected by rst.
  - Reset asserted mid-write: the clear wins.
- No handshake; mem_write is sampled on every edge.

## Test plan
- is_branch = 0, each flag_code 0–5, all select combinations, flags = 6'h3F -> branch_taken = 0 and out_target = next_pc.
- Jump mode:
  - is_branch = 1, sel_jflag_branch = 0, sel_jt_jf = 0, flag_code = 2, flags = 6'b000100 -> branch_taken = 1 and out_target = branch_addr.
  - Same with flags = 0 -> 0.
  - Same with sel_jt_jf = 1 and flags = 0 -> 1.
  - flag_code = 7 with jf -> 1.
- Branch mode:
  - sel_jflag_branch = 1, beq, flags[2] = 1 -> 1.
  - bne with flags[2] = 1 -> 0.
  - bne with flags = 0 and flag_code = 1 -> 1.
- Random sweep over 1024 vectors of flag_code 0–5, select bits and flags; compare branch_taken against the equations above.
- Memory:
  - rst low, then high -> reading address 5 gives 0.
  - Write 32'hDEADBEEF to address 5 -> out_mem_data = 32'hDEADBEEF after the edge.
  - Address 1029 reads the same word (wrap).
  - mem_write = 0 with new data -> value unchanged.
- Async reset: write 32'h12345678 to address 3, pulse rst low between clock edges -> out_mem_data = 0 immediately.

Source files
------------

// File: rtl/mem_stage.sv
// Memory stage of the core_lapido pipeline: branch resolution, a word-addressed
// data memory with asynchronous clear, and EX/MEM to MEM/WB pass-throughs.
module mem_stage #(
  parameter int PC_WIDTH = 32,
  parameter int MEM_AW   = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                is_branch,
  input  logic                sel_jflag_branch,
  input  logic                sel_jt_jf,
  input  logic                sel_beq_bne,
  input  logic [4:0]          flag_code,
  input  logic [5:0]          flags,
  input  logic                mem_write,
  input  logic [31:0]         mem_addr,
  input  logic [31:0]         mem_data,
  input  logic [PC_WIDTH-1:0] next_pc,
  input  logic [PC_WIDTH-1:0] branch_addr,
  input  logic [1:0]          wb_res_mux,
  input  logic [31:0]         alu_res,
  input  logic [4:0]          reg_dst,
  input  logic [31:0]         immediate,
  output logic                branch_taken,
  output logic [PC_WIDTH-1:0] out_target,
  output logic [PC_WIDTH-1:0] out_next_pc,
  output logic [31:0]         out_mem_data,
  output logic [1:0]          out_wb_res_mux,
  output logic [31:0]         out_alu_res,
  output logic [4:0]          out_reg_dst,
  output logic [31:0]         out_im
);

  localparam int DEPTH = 1 << MEM_AW;

  logic [31:0]       mem_r [DEPTH];
  logic [MEM_AW-1:0] index_s;
  logic              sel_flag_s;
  logic              taken_s;

  assign index_s = mem_addr[MEM_AW-1:0];

  // Select the flag tested by jt/jf; codes past OVERFLOW read as false.
  always_comb begin
    sel_flag_s = 1'b0;
    case (flag_code)
      5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5: sel_flag_s = flags[flag_code[2:0]];
      default:                            sel_flag_s = 1'b0;
    endcase
  end

  // Resolve the branch: jf/bne are the inverted senses of jt/beq.
  always_comb begin
    taken_s = 1'b0;
    if (!is_branch) begin
      taken_s = 1'b0;
    end else if (!sel_jflag_branch) begin
      taken_s = sel_flag_s ^ sel_jt_jf;
    end else begin
      taken_s = flags[2] ^ sel_beq_bne;
    end
  end

  // One register per word so the asynchronous clear needs no loop over the array.
  for (genvar g = 0; g < DEPTH; g++) begin : g_word
    // Word storage: cleared while rst is low, otherwise written when selected.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        mem_r[g] <= 32'h0000_0000;
      end else if (mem_write && (index_s == MEM_AW'(g))) begin
        mem_r[g] <= mem_data;
      end
    end
  end

  assign branch_taken   = taken_s;
  assign out_target     = taken_s ? branch_addr : next_pc;
  assign out_next_pc    = next_pc;
  assign out_mem_data   = mem_r[index_s];
  assign out_wb_res_mux = wb_res_mux;
  assign out_alu_res    = alu_res;
  assign out_reg_dst    = reg_dst;
  assign out_im         = immediate;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed and random branch vectors plus
// memory accesses compared against a word-array model of the data memory.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        is_branch, sel_jflag_branch, sel_jt_jf, sel_beq_bne;
  logic [4:0]  flag_code;
  logic [5:0]  flags;
  logic        mem_write;
  logic [31:0] mem_addr, mem_data;
  logic [31:0] next_pc, branch_addr;
  logic [1:0]  wb_res_mux;
  logic [31:0] alu_res;
  logic [4:0]  reg_dst;
  logic [31:0] immediate;
  logic        branch_taken;
  logic [31:0] out_target, out_next_pc, out_mem_data;
  logic [1:0]  out_wb_res_mux;
  logic [31:0] out_alu_res;
  logic [4:0]  out_reg_dst;
  logic [31:0] out_im;

  int checks = 0;
  int errors = 0;
  logic [31:0] model [1024];

  mem_stage #(.PC_WIDTH(32), .MEM_AW(10)) dut (
    .clk(clk), .rst(rst),
    .is_branch(is_branch), .sel_jflag_branch(sel_jflag_branch),
    .sel_jt_jf(sel_jt_jf), .sel_beq_bne(sel_beq_bne),
    .flag_code(flag_code), .flags(flags),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_data(mem_data),
    .next_pc(next_pc), .branch_addr(branch_addr),
    .wb_res_mux(wb_res_mux), .alu_res(alu_res), .reg_dst(reg_dst),
    .immediate(immediate),
    .branch_taken(branch_taken), .out_target(out_target),
    .out_next_pc(out_next_pc), .out_mem_data(out_mem_data),
    .out_wb_res_mux(out_wb_res_mux), .out_alu_res(out_alu_res),
    .out_reg_dst(out_reg_dst), .out_im(out_im)
  );

  always #5 clk = ~clk;

  // Instruction-level reference: jt/jf test the coded flag, beq/bne test ZERO.
  function automatic logic model_taken(input logic ib, input logic br_mode,
                                       input logic jf, input logic bne,
                                       input logic [4:0] fc, input logic [5:0] fl);
    logic flag_true;
    if (!ib) return 1'b0;
    if (br_mode) begin
      if (bne) return fl[2] == 1'b0;
      else     return fl[2] == 1'b1;
    end
    flag_true = (fc <= 5'd5) ? fl[fc] : 1'b0;
    if (jf) return !flag_true;
    else    return flag_true;
  endfunction

  task automatic drive_branch(input logic ib, input logic br_mode, input logic jf,
                              input logic bne, input logic [4:0] fc, input logic [5:0] fl);
    is_branch = ib; sel_jflag_branch = br_mode; sel_jt_jf = jf; sel_beq_bne = bne;
    flag_code = fc; flags = fl;
    next_pc = $urandom; branch_addr = $urandom;
    #1;
  endtask

  task automatic check_branch(input string name, input logic exp);
    logic [31:0] exp_tgt;
    exp_tgt = exp ? branch_addr : next_pc;
    checks++;
    if (branch_taken !== exp || out_target !== exp_tgt) begin
      errors++;
      $display("FAIL %s: taken=%b target=%h, expected taken=%b target=%h",
               name, branch_taken, out_target, exp, exp_tgt);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; mem_write = 1'b0; mem_addr = 32'd5; mem_data = 32'h0;
    drive_branch(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 6'h00);
    wb_res_mux = 2'd2; alu_res = 32'hCAFE_0001; reg_dst = 5'd9; immediate = 32'h0000_7777;
    #1;
    checks++;
    if (out_mem_data !== 32'h0) begin
      errors++; $display("FAIL reset_mem: got %h expected 0", out_mem_data);
    end
    checks++;
    if (out_next_pc !== next_pc || out_wb_res_mux !== 2'd2 || out_alu_res !== 32'hCAFE_0001
        || out_reg_dst !== 5'd9 || out_im !== 32'h0000_7777) begin
      errors++; $display("FAIL reset_passthru: outputs changed under reset");
    end
    @(negedge clk); rst = 1'b1;
    for (int i = 0; i < 1024; i++) model[i] = 32'h0;
    #1;
    checks++;
    if (out_mem_data !== 32'h0) begin
      errors++; $display("FAIL after_reset_addr5: got %h expected 0", out_mem_data);
    end
  endtask

  task automatic test_no_branch();
    for (int fc = 0; fc < 6; fc++)
      for (int s = 0; s < 8; s++) begin
        drive_branch(1'b0, s[0], s[1], s[2], 5'(fc), 6'h3F);
        check_branch("no_branch", 1'b0);
      end
  endtask

  task automatic test_jump();
    drive_branch(1'b1, 1'b0, 1'b0, 1'b0, 5'd2, 6'b000100); check_branch("jt_zero_set", 1'b1);
    drive_branch(1'b1, 1'b0, 1'b0, 1'b0, 5'd2, 6'b000000); check_branch("jt_zero_clr", 1'b0);
    drive_branch(1'b1, 1'b0, 1'b1, 1'b0, 5'd2, 6'b000000); check_branch("jf_zero_clr", 1'b1);
    drive_branch(1'b1, 1'b0, 1'b1, 1'b0, 5'd7, 6'h3F);     check_branch("jf_code7", 1'b1);
    drive_branch(1'b1, 1'b0, 1'b0, 1'b0, 5'd7, 6'h3F);     check_branch("jt_code7", 1'b0);
    drive_branch(1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 6'b100000); check_branch("jt_overflow", 1'b1);
  endtask

  task automatic test_branch();
    drive_branch(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 6'b000100); check_branch("beq_zero", 1'b1);
    drive_branch(1'b1, 1'b1, 1'b0, 1'b1, 5'd0, 6'b000100); check_branch("bne_zero", 1'b0);
    drive_branch(1'b1, 1'b1, 1'b0, 1'b1, 5'd1, 6'b000000); check_branch("bne_nozero", 1'b1);
    drive_branch(1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 6'b111011); check_branch("beq_nozero", 1'b0);
  endtask

  task automatic test_random_branch();
    logic [4:0] fc;
    for (int i = 0; i < 1088; i++) begin
      fc = (i < 1024) ? 5'($urandom_range(0, 5)) : 5'($urandom_range(6, 31));
      wb_res_mux = 2'($urandom); alu_res = $urandom; reg_dst = 5'($urandom); immediate = $urandom;
      drive_branch(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), fc, 6'($urandom));
      check_branch("random_branch",
                   model_taken(is_branch, sel_jflag_branch, sel_jt_jf, sel_beq_bne, flag_code, flags));
      if (i % 64 == 0) begin
        checks++;
        if (out_wb_res_mux !== wb_res_mux || out_alu_res !== alu_res || out_reg_dst !== reg_dst
            || out_im !== immediate || out_next_pc !== next_pc) begin
          errors++; $display("FAIL passthru: alu_res=%h expected %h", out_alu_res, alu_res);
        end
      end
    end
  endtask

  task automatic test_memory();
    @(negedge clk); mem_addr = 32'd5; mem_data = 32'hDEAD_BEEF; mem_write = 1'b1; #1;
    checks++;
    if (out_mem_data !== 32'h0) begin
      errors++; $display("FAIL pre_edge_read: got %h expected 0", out_mem_data);
    end
    @(posedge clk); #1; model[5] = 32'hDEAD_BEEF;
    checks++;
    if (out_mem_data !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL write_addr5: got %h expected deadbeef", out_mem_data);
    end
    @(negedge clk); mem_write = 1'b0; mem_addr = 32'd1029; #1;
    checks++;
    if (out_mem_data !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL wrap_1029: got %h expected deadbeef", out_mem_data);
    end
    mem_addr = 32'd5; mem_data = 32'h0BAD_F00D;
    @(posedge clk); #1;
    checks++;
    if (out_mem_data !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL no_write: got %h expected deadbeef", out_mem_data);
    end
  endtask

  task automatic test_random_memory();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      mem_addr = {$urandom_range(0, 7), 22'd0, 10'($urandom_range(0, 15))};
      mem_data = $urandom; mem_write = 1'($urandom); #1;
      checks++;
      if (out_mem_data !== model[mem_addr[9:0]]) begin
        errors++; $display("FAIL rand_mem addr=%h: got %h expected %h",
                           mem_addr, out_mem_data, model[mem_addr[9:0]]);
      end
      @(posedge clk);
      if (mem_write) model[mem_addr[9:0]] = mem_data;
    end
    @(negedge clk); mem_write = 1'b0;
  endtask

  task automatic test_async_reset();
    @(negedge clk); mem_addr = 32'd3; mem_data = 32'h1234_5678; mem_write = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_mem_data !== 32'h1234_5678) begin
      errors++; $display("FAIL write_addr3: got %h expected 12345678", out_mem_data);
    end
    mem_data = 32'hAAAA_5555; #1;
    rst = 1'b0; #1;
    checks++;
    if (out_mem_data !== 32'h0) begin
      errors++; $display("FAIL async_clear: got %h expected 0", out_mem_data);
    end
    @(posedge clk); #1;
    checks++;
    if (out_mem_data !== 32'h0) begin
      errors++; $display("FAIL write_in_reset: got %h expected 0", out_mem_data);
    end
    @(negedge clk); mem_write = 1'b0; rst = 1'b1; mem_addr = 32'd5; #1;
    checks++;
    if (out_mem_data !== 32'h0) begin
      errors++; $display("FAIL clear_addr5: got %h expected 0", out_mem_data);
    end
  endtask

  initial begin
    test_reset();
    test_no_branch();
    test_jump();
    test_branch();
    test_random_branch();
    test_memory();
    test_random_memory();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
